// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, the stall/flush
// control bundle and the load-use detection rule.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StMdWait
    } hz_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
    } hz_ctrl_t;

    localparam hz_ctrl_t CtrlNone = '{
        stall_if: 1'b0, stall_id: 1'b0, stall_ex: 1'b0,
        flush_id: 1'b0, flush_ex: 1'b0, flush_mem: 1'b0
    };

    // Bubbles fill IF/ID and ID/EX while the pipe comes out of reset.
    localparam hz_ctrl_t CtrlBoot = '{
        stall_if: 1'b0, stall_id: 1'b0, stall_ex: 1'b0,
        flush_id: 1'b1, flush_ex: 1'b1, flush_mem: 1'b0
    };

    // Freeze everything up to EX and feed bubbles into MEM while mul/div runs.
    localparam hz_ctrl_t CtrlMdStall = '{
        stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1,
        flush_id: 1'b0, flush_ex: 1'b0, flush_mem: 1'b1
    };

    localparam hz_ctrl_t CtrlRedirect = '{
        stall_if: 1'b0, stall_id: 1'b0, stall_ex: 1'b0,
        flush_id: 1'b1, flush_ex: 1'b1, flush_mem: 1'b0
    };

    localparam hz_ctrl_t CtrlLoadUse = '{
        stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b0,
        flush_id: 1'b0, flush_ex: 1'b1, flush_mem: 1'b0
    };

    // x0 never carries a real dependency, so a load to x0 cannot cause a hazard.
    function automatic logic load_use(
        input logic [4:0] rs1_addr,
        input logic [4:0] rs2_addr,
        input logic       rs1_re,
        input logic       rs2_re,
        input logic [4:0] rd_addr,
        input logic       rd_we,
        input logic       is_load
    );
        logic hit1;
        logic hit2;
        hit1 = rs1_re && (rs1_addr == rd_addr);
        hit2 = rs2_re && (rs2_addr == rd_addr);
        return is_load && rd_we && (rd_addr != 5'd0) && (hit1 || hit2);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module hazard_ctrl_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/flush controls for load-use, EX redirects and
// multi-cycle mul/div held in EX, with a watchdog on the mul/div wait.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_re_i,
    input  logic             id_rs2_re_i,
    input  logic [4:0]       exe_rdaddr_i,
    input  logic             exe_rdwe_i,
    input  logic             exe_is_load_i,
    input  logic             exe_md_start_i,
    input  logic             md_done_i,
    input  logic             exe_redirect_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             flush_mem_o,
    output logic             md_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned TO_W = $clog2(MD_TIMEOUT);
    localparam logic [TO_W-1:0] WaitLast = TO_W'(MD_TIMEOUT - 1);

    hz_state_e       state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;
    hz_ctrl_t        ctrl;
    logic            lu_hazard;

    assign lu_hazard = load_use(id_rs1_addr_i, id_rs2_addr_i, id_rs1_re_i, id_rs2_re_i,
                                exe_rdaddr_i, exe_rdwe_i, exe_is_load_i);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        ctrl       = CtrlNone;
        unique case (state_q)
            StInit: begin
                ctrl    = CtrlBoot;
                state_d = StRun;
            end
            StRun: begin
                // A mul/div finishing in its first EX cycle costs nothing.
                if (exe_md_start_i && !md_done_i) begin
                    ctrl       = CtrlMdStall;
                    state_d    = StMdWait;
                    wait_cnt_d = TO_W'(1);
                end else if (exe_redirect_i) begin
                    ctrl = CtrlRedirect;
                end else if (lu_hazard) begin
                    ctrl = CtrlLoadUse;
                end
            end
            StMdWait: begin
                if (md_done_i) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitLast) begin
                    // Give up on the unit and release the pipe; flag stays set until reset.
                    timeout_d  = 1'b1;
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else begin
                    ctrl       = CtrlMdStall;
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d    = StInit;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stall_if_o   = ctrl.stall_if;
    assign stall_id_o   = ctrl.stall_id;
    assign stall_ex_o   = ctrl.stall_ex;
    assign flush_id_o   = ctrl.flush_id;
    assign flush_ex_o   = ctrl.flush_ex;
    assign flush_mem_o  = ctrl.flush_mem;
    assign md_timeout_o = timeout_q;

    hazard_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ctrl.stall_if),
        .count_o (stall_cnt_o)
    );

endmodule
